uart_sync_fifo: RTL and testbench

Single-clock, parametrised data FIFO for the UART datapath, buffering bytes between the receive framer and its downstream consumer when both run on one clock domain. Generalises the existing buffer with full, almost-full and almost-empty flags, a fill-level output, same-cycle read/write, and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through (FWFT) or registered-read output.

---
 rtl/uart_sync_fifo.sv | 90 +++++++++
 tb/tb_uart_sync_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO for the UART datapath with level, threshold and sticky error flags.
// Define UART_SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module uart_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic [LW-1:0]         level_nxt_c;

    // Accept decode; a full FIFO takes a write only when a read frees a slot this cycle.
    always_comb begin
        rd_acc_c    = rd_en && !empty;
        wr_acc_c    = wr_en && (!full || rd_acc_c);
        level_nxt_c = level + LW'(wr_acc_c) - LW'(rd_acc_c);
    end

    // Pointers, level, flags decoded from the next level so they track the level register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc_c) rd_ptr <= rd_ptr + AW'(1);
            level        <= level_nxt_c;
            empty        <= (level_nxt_c == '0);
            full         <= (level_nxt_c == LW'(DEPTH));
            almost_full  <= (level_nxt_c >= LW'(AF_THRESH));
            almost_empty <= (level_nxt_c <= LW'(AE_THRESH));
            overflow     <= (wr_en && !wr_acc_c) || (overflow && !clr_err);
            underflow    <= (rd_en && !rd_acc_c) || (underflow && !clr_err);
        end
    end

    // Storage is not reset; writes are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_c) mem[wr_ptr] <= data_in;
    end

`ifdef UART_SYNC_FIFO_FWFT_EN
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty;
`else
    // Registered read: one-cycle valid pulse per accepted pop, data held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc_c;
            if (rd_acc_c) data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed scoreboard bench for uart_sync_fifo (default parameters, either output mode).
module tb_uart_sync_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    level;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    uart_sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests;
    int            fails;
    logic [DW-1:0] exp_q [$];
    int unsigned   m_level;
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = '0;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(m_level));
        chk({tag, ".full"}, 32'(full), 32'(m_level == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_level == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(m_level >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_level <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus with scoreboard update and post-edge checks.
    task automatic step(input string tag, input logic wr, input logic [DW-1:0] din,
                        input logic rd, input logic clr);
        logic          r_acc;
        logic          w_acc;
        logic [DW-1:0] popped;
        r_acc  = rd && (m_level != 0);
        w_acc  = wr && ((m_level != DEPTH) || r_acc);
        popped = '0;
`ifdef UART_SYNC_FIFO_FWFT_EN
        chk({tag, ".fwft_valid"}, 32'(data_valid), 32'(m_level != 0));
        if (m_level != 0) chk({tag, ".fwft_head"}, 32'(data_out), 32'(exp_q[0]));
`endif
        if (r_acc) popped = exp_q.pop_front();
        if (w_acc) exp_q.push_back(din);
        m_level = m_level + (w_acc ? 1 : 0) - (r_acc ? 1 : 0);
        m_ovf   = (wr && !w_acc) || (m_ovf && !clr);
        m_unf   = (rd && !r_acc) || (m_unf && !clr);
        if (r_acc) m_last = popped;
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        clr_err = clr;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        chk_flags(tag);
`ifndef UART_SYNC_FIFO_FWFT_EN
        chk({tag, ".dvalid"}, 32'(data_valid), 32'(r_acc));
        chk({tag, ".dout"}, 32'(data_out), 32'(m_last));
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk_flags(tag);
        chk({tag, ".dvalid"}, 32'(data_valid), 32'd0);
`ifndef UART_SYNC_FIFO_FWFT_EN
        chk({tag, ".dout"}, 32'(data_out), 32'd0);
`endif
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        data_in = '0;
        model_reset();
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;

        // Fill, then a rejected write of 0xFF.
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        step("fill_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);

        // Drain in order, then a rejected read.
        for (int i = 0; i < 16; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("drain_unf", 1'b0, '0, 1'b1, 1'b0);
        step("clr", 1'b0, '0, 1'b0, 1'b1);

        // Wrap-around with alternating write/read pairs.
        for (int i = 0; i < 40; i++) begin
            step("wrap_wr", 1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
            step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
        end

        // Simultaneous write/read while full.
        for (int i = 0; i < 16; i++) step("refill", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step("full_drain", 1'b0, '0, 1'b1, 1'b0);
        chk("aa_last", 32'(m_last), 32'h0000_00AA);

        // Simultaneous write/read while empty: no bypass.
        step("empty_rw", 1'b1, 8'h55, 1'b1, 1'b0);
        step("empty_rd55", 1'b0, '0, 1'b1, 1'b0);
        step("set_wins", 1'b0, '0, 1'b1, 1'b1);
        step("clr_only", 1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation with requests held during reset.
        for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h99;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        model_reset();
        chk_reset("mid_rst");
        rst_n = 1'b1;
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
